// File: rtl/tlb_miss_queue_if.sv
// tlb_miss_queue_if: DTLB miss request, L2 TLB walk and DTLB completion signals
// master: DTLB/L2 side drives req_*, flush, ptw_ready, ptw_resp_*; observes req_ready, ptw_req/vpn, resp_*
// slave:  the miss queue itself
interface tlb_miss_queue_if #(parameter int VPN_W = 27, parameter int IDX_W = 6);
  logic             req_valid;
  logic             req_ready;
  logic [VPN_W-1:0] req_vpn;
  logic [1:0]       req_source;
  logic [IDX_W-1:0] req_idx;
  logic             flush;
  logic             ptw_req;
  logic [VPN_W-1:0] ptw_vpn;
  logic             ptw_ready;
  logic             ptw_resp_valid;
  logic             ptw_resp_exception;
  logic             ptw_resp_error;
  logic             resp_valid;
  logic [VPN_W-1:0] resp_vpn;
  logic [1:0]       resp_source;
  logic [IDX_W-1:0] resp_idx;
  logic             resp_exception;
  logic             resp_error;
  modport master (
    output req_valid, req_vpn, req_source, req_idx, flush, ptw_ready, ptw_resp_valid,
           ptw_resp_exception, ptw_resp_error,
    input  req_ready, ptw_req, ptw_vpn, resp_valid, resp_vpn, resp_source, resp_idx,
           resp_exception, resp_error
  );
  modport slave (
    input  req_valid, req_vpn, req_source, req_idx, flush, ptw_ready, ptw_resp_valid,
           ptw_resp_exception, ptw_resp_error,
    output req_ready, ptw_req, ptw_vpn, resp_valid, resp_vpn, resp_source, resp_idx,
           resp_exception, resp_error
  );
endinterface

// File: rtl/tlb_miss_queue.sv
// tlb_miss_queue: merging FIFO of DTLB misses issuing one page walk at a time to the L2 TLB
// clk, rst (async, active-low); bus: request, walk and completion signals (slave side)
module tlb_miss_queue #(
  parameter int DEPTH = 4,
  parameter int VPN_W = 27,
  parameter int IDX_W = 6
) (
  input logic           clk,
  input logic           rst,
  tlb_miss_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t           state;
  logic [VPN_W-1:0] vpn_q [DEPTH];
  logic [1:0]       src_q [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [PW-1:0]    head, tail, off;
  logic [PW:0]      count;
  logic             drop, hit, alloc, pop;
  // an entry is live when its distance from head is below count
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count && vpn_q[i] == bus.req_vpn && src_q[i] == bus.req_source) hit = 1'b1;
    end
  end
  assign bus.req_ready = count < (PW + 1)'(DEPTH);
  assign bus.ptw_vpn   = vpn_q[head];
  assign alloc         = bus.req_valid & bus.req_ready & ~hit & ~bus.flush;
  assign pop           = (state == WAIT) & bus.ptw_resp_valid;
  always_ff @(posedge clk) begin
    if (alloc) begin
      vpn_q[tail] <= bus.req_vpn;
      src_q[tail] <= bus.req_source;
      idx_q[tail] <= bus.req_idx;
    end
    if (pop) begin
      bus.resp_vpn       <= vpn_q[head];
      bus.resp_source    <= src_q[head];
      bus.resp_idx       <= idx_q[head];
      bus.resp_exception <= bus.ptw_resp_exception;
      bus.resp_error     <= bus.ptw_resp_error;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      drop           <= 1'b0;
      bus.ptw_req    <= 1'b0;
      bus.resp_valid <= 1'b0;
    end else begin
      bus.resp_valid <= pop & ~drop & ~bus.flush;
      if (bus.flush && state != WAIT) begin
        state       <= IDLE;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        bus.ptw_req <= 1'b0;
      end else if (bus.flush) begin
        // keep only the in-flight head so its walk response can still retire it
        head  <= head + PW'(pop);
        tail  <= head + PW'(1);
        count <= pop ? '0 : (PW + 1)'(1);
        drop  <= ~pop;
        state <= pop ? IDLE : WAIT;
      end else begin
        head  <= head + PW'(pop);
        tail  <= tail + PW'(alloc);
        count <= count + (PW + 1)'(alloc) - (PW + 1)'(pop);
        if (pop) drop <= 1'b0;
        case (state)
          IDLE: if (count != '0) begin
            state       <= REQ;
            bus.ptw_req <= 1'b1;
          end
          REQ: if (bus.ptw_ready) begin
            state       <= WAIT;
            bus.ptw_req <= 1'b0;
          end
          WAIT: if (pop) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tlb_miss_queue.sv
// tb_tlb_miss_queue: directed stimulus with scoreboarded walk requests and completions
module tb_tlb_miss_queue;
  typedef struct packed {
    logic [26:0] vpn;
    logic [1:0]  src;
    logic [5:0]  idx;
    logic        exc;
    logic        err;
  } resp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passes = 0;
  logic [26:0] exp_ptw [$];
  resp_t exp_resp [$];
  tlb_miss_queue_if #(.VPN_W(27), .IDX_W(6)) bus ();
  tlb_miss_queue #(.DEPTH(4), .VPN_W(27), .IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  always @(negedge clk) begin
    if (rst && bus.ptw_req && bus.ptw_ready) begin
      if (exp_ptw.size() == 0) begin
        checks++;
        $display("FAIL ptw_unexpected: got vpn %0h expected no walk", bus.ptw_vpn);
      end else check("ptw_vpn", bus.ptw_vpn, exp_ptw.pop_front());
    end
    if (rst && bus.resp_valid) begin
      if (exp_resp.size() == 0) begin
        checks++;
        $display("FAIL resp_unexpected: got vpn %0h expected no response", bus.resp_vpn);
      end else check("resp_payload",
                     {bus.resp_vpn, bus.resp_source, bus.resp_idx, bus.resp_exception, bus.resp_error},
                     exp_resp.pop_front());
    end
  end
  task automatic expect_walk(input logic [26:0] v, input logic [1:0] s, input logic [5:0] x,
                             input logic exc, input logic err);
    exp_ptw.push_back(v);
    exp_resp.push_back('{vpn: v, src: s, idx: x, exc: exc, err: err});
  endtask
  task automatic enq(input logic [26:0] v, input logic [1:0] s, input logic [5:0] x);
    bus.req_valid = 1'b1;
    bus.req_vpn = v;
    bus.req_source = s;
    bus.req_idx = x;
    check("enq_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic issue();
    int n = 0;
    bus.ptw_ready = 1'b1;
    while (!bus.ptw_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_in_time", n < 20, 1);
    @(posedge clk); #1;
    bus.ptw_ready = 1'b0;
  endtask
  task automatic finish(input logic exc, input logic err, input logic exp_rv, input bit pulse_chk);
    bus.ptw_resp_valid = 1'b1;
    bus.ptw_resp_exception = exc;
    bus.ptw_resp_error = err;
    @(posedge clk); #1;
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_exception = 1'b0;
    bus.ptw_resp_error = 1'b0;
    check("resp_valid_timing", bus.resp_valid, exp_rv);
    if (pulse_chk) begin
      @(posedge clk); #1;
      check("resp_pulse_width", bus.resp_valid, 0);
    end
  endtask
  task automatic idle_check(input string name);
    logic seen = 1'b0;
    bus.ptw_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | bus.ptw_req;
    end
    bus.ptw_ready = 1'b0;
    check(name, seen, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_vpn = '0;
    bus.req_source = '0;
    bus.req_idx = '0;
    bus.flush = 1'b0;
    bus.ptw_ready = 1'b0;
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_exception = 1'b0;
    bus.ptw_resp_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_ptw_req", bus.ptw_req, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    // single miss: issue latency and completion
    expect_walk(27'h12345, 2'b01, 6'd3, 1'b0, 1'b0);
    enq(27'h12345, 2'b01, 6'd3);
    check("issue_not_early", bus.ptw_req, 0);
    @(posedge clk); #1;
    check("issue_latency", bus.ptw_req, 1);
    check("issue_vpn", bus.ptw_vpn, 27'h12345);
    issue();
    finish(1'b0, 1'b0, 1'b1, 1'b1);
    // fill to full, hold a fifth request across the pop
    for (int i = 0; i < 4; i++) begin
      expect_walk(27'h100 + 27'(i), 2'b01, 6'(i), 1'b0, 1'b0);
      enq(27'h100 + 27'(i), 2'b01, 6'(i));
    end
    check("full_ready", bus.req_ready, 0);
    expect_walk(27'h104, 2'b01, 6'd4, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_vpn = 27'h104;
    bus.req_source = 2'b01;
    bus.req_idx = 6'd4;
    issue();
    check("held_ready", bus.req_ready, 0);
    finish(1'b0, 1'b0, 1'b1, 1'b0);
    check("ready_after_pop", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("resp_pulse_full", bus.resp_valid, 0);
    check("refull_ready", bus.req_ready, 0);
    repeat (4) begin
      issue();
      finish(1'b0, 1'b0, 1'b1, 1'b1);
    end
    // merge: same vpn and source allocates once
    expect_walk(27'hA, 2'b10, 6'd5, 1'b0, 1'b0);
    enq(27'hA, 2'b10, 6'd5);
    enq(27'hA, 2'b10, 6'd6);
    expect_walk(27'hA, 2'b01, 6'd7, 1'b0, 1'b0);
    enq(27'hA, 2'b01, 6'd7);
    repeat (2) begin
      issue();
      finish(1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle_check("merge_no_third_walk");
    // outcome flags pass through, next entry still issues
    expect_walk(27'h55, 2'b11, 6'd9, 1'b0, 1'b1);
    enq(27'h55, 2'b11, 6'd9);
    expect_walk(27'h56, 2'b01, 6'd10, 1'b1, 1'b0);
    enq(27'h56, 2'b01, 6'd10);
    issue();
    finish(1'b0, 1'b1, 1'b1, 1'b1);
    issue();
    finish(1'b1, 1'b0, 1'b1, 1'b1);
    // flush while a walk is in flight
    exp_ptw.push_back(27'h200);
    enq(27'h200, 2'b01, 6'd1);
    enq(27'h201, 2'b01, 6'd2);
    enq(27'h202, 2'b01, 6'd3);
    issue();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("wait_flush_ready", bus.req_ready, 1);
    finish(1'b0, 1'b0, 1'b0, 1'b1);
    idle_check("wait_flush_no_walk");
    // flush while requesting, with a colliding enqueue
    enq(27'h400, 2'b01, 6'd1);
    @(posedge clk); #1;
    check("req_state_ptw_req", bus.ptw_req, 1);
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_vpn = 27'h401;
    check("ready_during_flush", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_drops_ptw_req", bus.ptw_req, 0);
    idle_check("req_flush_no_walk");
    // asynchronous reset during a walk with a full queue
    exp_ptw.push_back(27'h300);
    for (int i = 0; i < 4; i++) enq(27'h300 + 27'(i), 2'b01, 6'(i));
    issue();
    check("full_before_reset", bus.req_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ready", bus.req_ready, 1);
    check("async_rst_resp", bus.resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    finish(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_ready", bus.req_ready, 1);
    idle_check("post_rst_idle");
    check("ptw_sb_empty", exp_ptw.size(), 0);
    check("resp_sb_empty", exp_resp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
